// File: rtl/lcd_gpio_bidir.sv
// lcd_gpio_bidir
//   Parametrised bidirectional PIO for the LCD/touch-controller pins, behind
//   one Avalon-MM slave. Each of the WIDTH pins has its own direction bit.
//   Software can also set or clear output bits atomically. Pin inputs pass
//   through a synchroniser. Edges on the synchronised inputs are captured,
//   and a maskable level interrupt is raised from the captured edges.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   address     word address: 0 DATA, 1 DIR, 2 IRQ_MASK, 3 EDGE_CAP,
//               4 OUTSET, 5 OUTCLEAR, 6/7 reserved
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data, bits above WIDTH ignored
//   readdata    registered read data (latency 1, no read side effects)
//   irq         level interrupt, |(EDGE_CAP & IRQ_MASK), registered
//   bidir_port  device pins, driven where DIR = 1, tristated otherwise
module lcd_gpio_bidir #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 1,
  parameter logic [WIDTH-1:0] RESET_OUT   = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] RESET_DIR   = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] bidir_port
);

  // Arming completes once the sync chain and prev both hold real pin data.
  localparam int         ARM_MAX_I = SYNC_STAGES + 1;
  localparam logic [2:0] ARM_MAX   = 3'(ARM_MAX_I);

  logic [WIDTH-1:0] data_out_r;
  logic [WIDTH-1:0] dir_r;
  logic [WIDTH-1:0] irq_mask_r;
  logic [WIDTH-1:0] edge_cap_r;
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [2:0]       arm_cnt_r;

  logic             wr_en_s;
  logic [WIDTH-1:0] wdata_s;
  logic [WIDTH-1:0] sync_out_s;
  logic [WIDTH-1:0] data_out_nxt_s;
  logic [WIDTH-1:0] dir_nxt_s;
  logic [WIDTH-1:0] irq_mask_nxt_s;
  logic [WIDTH-1:0] w1c_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] edge_set_s;
  logic [WIDTH-1:0] edge_cap_nxt_s;
  logic             armed_s;
  logic [31:0]      rd_s;
  logic             unused_wdata_s;

  assign wr_en_s    = chipselect & ~write_n;
  assign wdata_s    = writedata[WIDTH-1:0];
  assign sync_out_s = sync_r[SYNC_STAGES-1];
  assign armed_s    = (arm_cnt_r == ARM_MAX);

  // Bits of writedata above WIDTH carry no meaning for this block.
  assign unused_wdata_s = ^writedata;

  // Per-pin tristate driver.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = dir_r[i] ? data_out_r[i] : 1'bz;
  end

  // Register write decode; only one address is written per cycle.
  always_comb begin
    data_out_nxt_s = data_out_r;
    dir_nxt_s      = dir_r;
    irq_mask_nxt_s = irq_mask_r;
    w1c_s          = {WIDTH{1'b0}};
    if (wr_en_s) begin
      case (address)
        3'd0:    data_out_nxt_s = wdata_s;
        3'd1:    dir_nxt_s      = wdata_s;
        3'd2:    irq_mask_nxt_s = wdata_s;
        3'd3:    w1c_s          = wdata_s;
        3'd4:    data_out_nxt_s = data_out_r | wdata_s;
        3'd5:    data_out_nxt_s = data_out_r & ~wdata_s;
        default: data_out_nxt_s = data_out_r;
      endcase
    end else begin
      data_out_nxt_s = data_out_r;
    end
  end

  // Edge detection on the synchronised inputs, selected by EDGE_TYPE.
  always_comb begin
    edge_s = {WIDTH{1'b0}};
    case (EDGE_TYPE)
      0:       edge_s = sync_out_s & ~prev_r;
      1:       edge_s = ~sync_out_s & prev_r;
      default: edge_s = sync_out_s ^ prev_r;
    endcase
  end

  // A new edge beats a software clear of the same bit in the same cycle.
  always_comb begin
    edge_set_s     = armed_s ? edge_s : {WIDTH{1'b0}};
    edge_cap_nxt_s = (edge_cap_r & ~w1c_s) | edge_set_s;
  end

  // Read mux; reserved and write-only addresses read as zero.
  always_comb begin
    rd_s = 32'd0;
    case (address)
      3'd0:    rd_s[WIDTH-1:0] = sync_out_s;
      3'd1:    rd_s[WIDTH-1:0] = dir_r;
      3'd2:    rd_s[WIDTH-1:0] = irq_mask_r;
      3'd3:    rd_s[WIDTH-1:0] = edge_cap_r;
      default: rd_s = 32'd0;
    endcase
  end

  // Input synchroniser chain and previous-value register for edge detect.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {WIDTH{1'b0}};
      end
      prev_r <= {WIDTH{1'b0}};
    end else begin
      sync_r[0] <= bidir_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= sync_out_s;
    end
  end

  // Arming counter: suppresses capture until the input pipeline is filled.
  always_ff @(posedge clk) begin
    if (reset) begin
      arm_cnt_r <= 3'd0;
    end else if (!armed_s) begin
      arm_cnt_r <= arm_cnt_r + 3'd1;
    end else begin
      arm_cnt_r <= arm_cnt_r;
    end
  end

  // Control/status registers, interrupt and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_r <= RESET_OUT;
      dir_r      <= RESET_DIR;
      irq_mask_r <= {WIDTH{1'b0}};
      edge_cap_r <= {WIDTH{1'b0}};
      irq        <= 1'b0;
      readdata   <= 32'd0;
    end else begin
      data_out_r <= data_out_nxt_s;
      dir_r      <= dir_nxt_s;
      irq_mask_r <= irq_mask_nxt_s;
      edge_cap_r <= edge_cap_nxt_s;
      irq        <= |(edge_cap_r & irq_mask_r);
      readdata   <= rd_s;
    end
  end

endmodule

// File: tb/tb_lcd_gpio_bidir.sv
// tb_lcd_gpio_bidir
//   Directed bench for lcd_gpio_bidir with WIDTH=8, SYNC_STAGES=2,
//   EDGE_TYPE=1 (falling), RESET_OUT=8'hA5, RESET_DIR=8'h0F.
//   An external driver model acts on pins that have ext_en set.
module tb_lcd_gpio_bidir;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  wire  [7:0]  bidir_port;

  logic [7:0]  ext_en;
  logic [7:0]  ext_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 8; i++) begin : g_ext
    assign bidir_port[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  lcd_gpio_bidir #(
    .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1),
    .RESET_OUT(8'hA5), .RESET_DIR(8'h0F)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .bidir_port(bidir_port)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One write cycle; returns #1 after the edge on which it lands.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // Present an address, then compare readdata after the next edge.
  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a;
    @(posedge clk);
    #1;
    chk(tag, readdata, exp);
  endtask

  initial begin
    reset = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'd0; ext_en = 8'hF0; ext_val = 8'hFF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_pins_lo", {28'd0, bidir_port[3:0]}, 32'h5);
    chk("rst_pins_all", {24'd0, bidir_port}, 32'hF5);
    @(negedge clk);
    reset = 1'b0; address = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_rd", readdata, 32'hF5);
    repeat (4) @(posedge clk);
    rd("rst_no_spurious_cap", 3'd3, 32'h0);

    // Outputs: DATA, OUTSET, OUTCLEAR with loopback readback
    ext_en = 8'h00;
    wr(3'd1, 32'hFF);
    wr(3'd0, 32'h3C);
    chk("pins_data", {24'd0, bidir_port}, 32'h3C);
    repeat (2) @(posedge clk);
    rd("rd_data_3c", 3'd0, 32'h3C);
    wr(3'd4, 32'h81);
    chk("pins_outset", {24'd0, bidir_port}, 32'hBD);
    repeat (2) @(posedge clk);
    rd("rd_data_bd", 3'd0, 32'hBD);
    wr(3'd5, 32'h0C);
    chk("pins_outclr", {24'd0, bidir_port}, 32'hB1);
    repeat (2) @(posedge clk);
    rd("rd_data_b1", 3'd0, 32'hB1);
    rd("rd_outset_zero", 3'd4, 32'h0);
    rd("rd_dir_ff", 3'd1, 32'hFF);

    // Falling edge on pin 2 with mask 04
    wr(3'd1, 32'h00);
    ext_en = 8'hFF; ext_val = 8'hFF;
    repeat (6) @(posedge clk);
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h04);
    rd("cap_cleared", 3'd3, 32'h0);
    chk("irq_idle", {31'd0, irq}, 32'd0);
    @(negedge clk);
    ext_val = 8'hFB; address = 3'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("cap_not_early", readdata, 32'h0);
    chk("irq_not_early", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    chk("cap_pin2", readdata, 32'h04);
    chk("irq_pin2", {31'd0, irq}, 32'd1);
    wr(3'd3, 32'h04);
    chk("irq_hold_w1c_edge", {31'd0, irq}, 32'd1);
    @(posedge clk);
    #1;
    chk("irq_cleared", {31'd0, irq}, 32'd0);

    // Masked edge on pin 5, then unmask
    @(negedge clk);
    ext_val = 8'hDB;
    repeat (5) @(posedge clk);
    #1;
    chk("irq_masked", {31'd0, irq}, 32'd0);
    rd("cap_pin5", 3'd3, 32'h20);
    wr(3'd2, 32'h20);
    chk("irq_unmask_lat", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    chk("irq_unmasked", {31'd0, irq}, 32'd1);

    // Set beats W1C on the same bit in the same cycle
    @(negedge clk);
    ext_val = 8'hDA;
    repeat (5) @(posedge clk);
    rd("cap_bit0", 3'd3, 32'h21);
    @(negedge clk);
    ext_val = 8'hDB;
    repeat (5) @(posedge clk);
    rd("cap_rise_ignored", 3'd3, 32'h21);
    @(negedge clk);
    ext_val = 8'hDA;
    @(posedge clk);
    @(posedge clk);
    wr(3'd3, 32'h01);
    rd("set_beats_w1c", 3'd3, 32'h21);
    wr(3'd3, 32'h01);
    rd("w1c_alone", 3'd3, 32'h20);

    // Reset mid-operation
    chk("irq_before_rst", {31'd0, irq}, 32'd1);
    wr(3'd0, 32'hFF);
    @(negedge clk);
    reset = 1'b1; ext_en = 8'hF0; ext_val = 8'hFF;
    @(posedge clk);
    #1;
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    chk("mid_rst_readdata", readdata, 32'd0);
    chk("mid_rst_pins_lo", {28'd0, bidir_port[3:0]}, 32'h5);
    @(negedge clk);
    reset = 1'b0; address = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_data_rd", readdata, 32'hF5);
    rd("mid_rst_dir", 3'd1, 32'h0F);
    rd("mid_rst_cap", 3'd3, 32'h0);
    rd("mid_rst_mask", 3'd2, 32'h0);
    rd("rd_addr6", 3'd6, 32'h0);
    rd("rd_addr7", 3'd7, 32'h0);
    wr(3'd6, 32'hFF);
    rd("wr6_ignored", 3'd1, 32'h0F);
    rd("rd_outclr_zero", 3'd5, 32'h0);
    chk("mid_rst_irq_stays", {31'd0, irq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
